// File: rtl/cv_btn_bounce_gen_pkg.sv
// Shared definitions for the contact-bounce emulator.
//   - FSM state encoding (IDLE / BOUNCE / SETTLE; the unused code 2'b11 recovers to IDLE)
//   - LFSR width and Galois tap mask for x^8+x^6+x^5+x^4+1
//   - lfsr_step(): one step of the right-shifting Galois LFSR
package cv_bounce_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_BOUNCE = 2'b01;
  localparam logic [1:0] ST_SETTLE = 2'b10;

  // Right shift; when the bit that falls out is 1, fold the tap mask back in.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
  endfunction

endpackage

// File: rtl/cv_btn_bounce_gen_if.sv
// Signal bundle of the bounce emulator.
//   master : drives CE and LVL_IN; observes BTN_OUT, BUSY, DONE and the debug taps
//   slave  : the emulator itself
// Debug taps: dbg_state (FSM state), dbg_cnt (tick counter), dbg_lfsr (LFSR contents).
// Handshake: there is no valid/ready pair. LVL_IN is a level that is sampled on
// every CLK edge while the emulator is idle. A change seen while BUSY is high is
// not stored. DONE is a single-CLK strobe that marks the settled end of a transition.
interface cv_btn_bounce_gen_if
  import cv_bounce_pkg::*;
#(
  parameter int CNT_WIDTH = 5
);
  logic                 CE;
  logic                 LVL_IN;
  logic                 BTN_OUT;
  logic                 BUSY;
  logic                 DONE;
  logic [1:0]           dbg_state;
  logic [CNT_WIDTH-1:0] dbg_cnt;
  logic [LFSR_W-1:0]    dbg_lfsr;

  modport master (
    output CE, LVL_IN,
    input  BTN_OUT, BUSY, DONE, dbg_state, dbg_cnt, dbg_lfsr
  );

  modport slave (
    input  CE, LVL_IN,
    output BTN_OUT, BUSY, DONE, dbg_state, dbg_cnt, dbg_lfsr
  );
endinterface

// File: rtl/cv_lfsr8.sv
// 8-bit Galois LFSR, taps 8'hB8, period 255.
//   CLK, RST (async, active-high) : clock / reset to SEED
//   EN                            : advance one step on this edge
//   Q                             : current contents
//   Q_NEXT                        : value Q takes after the next enabled step
module cv_lfsr8
  import cv_bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic [LFSR_W-1:0] Q,
  output logic [LFSR_W-1:0] Q_NEXT
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    Q_NEXT = lfsr_step(lfsr_q);
    lfsr_d = EN ? Q_NEXT : lfsr_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign Q = lfsr_q;

endmodule

// File: rtl/cv_btn_bounce_gen.sv
// Contact-bounce emulator. It turns a clean command level into a chattering
// "mechanical" output. The output chatters for BOUNCE_LEN CE ticks and then
// holds the new level for SETTLE_LEN CE ticks before DONE is raised.
//   CLK, RST  : clock, asynchronous active-high reset
//   bus.CE    : tick enable (shared with the downstream debounce filter)
//   bus.LVL_IN: clean command level
//   bus.BTN_OUT: registered bouncing output
//   bus.BUSY  : high in BOUNCE or SETTLE
//   bus.DONE  : one-CLK pulse when a transition has settled
//   bus.dbg_* : FSM state, tick counter and LFSR contents
module cv_btn_bounce_gen
  import cv_bounce_pkg::*;
#(
  parameter int                CNT_WIDTH  = 5,
  parameter int                BOUNCE_LEN = 12,
  parameter int                SETTLE_LEN = 20,
  parameter logic [LFSR_W-1:0] SEED       = 8'hA5
) (
  input  logic               CLK,
  input  logic               RST,
  cv_btn_bounce_gen_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] BOUNCE_LAST = CNT_WIDTH'(BOUNCE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_LEN - 1);

  logic [1:0]           state_q, state_d;
  logic                 tgt_q,   tgt_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 btn_q,   btn_d;
  logic                 done_q,  done_d;

  logic                 lfsr_en;
  logic [LFSR_W-1:0]    lfsr_q;
  logic [LFSR_W-1:0]    lfsr_next;

  cv_lfsr8 #(.SEED(SEED)) u_lfsr (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (lfsr_en),
    .Q      (lfsr_q),
    .Q_NEXT (lfsr_next)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    done_d  = 1'b0;
    lfsr_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        btn_d = tgt_q;
        // Mismatch detection ignores CE so that BUSY follows the command within one CLK.
        if (bus.LVL_IN != tgt_q) begin
          tgt_d   = bus.LVL_IN;
          cnt_d   = '0;
          state_d = ST_BOUNCE;
        end
      end

      ST_BOUNCE: begin
        if (bus.CE) begin
          lfsr_en = 1'b1;
          if (cnt_q == BOUNCE_LAST) begin
            // The last chatter tick lands on the target, so SETTLE starts clean.
            btn_d   = tgt_q;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            btn_d = lfsr_next[0];
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        btn_d = tgt_q;
        if (bus.CE) begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      done_q  <= done_d;
    end
  end

  // BUSY decodes the registered state, so it drops on the same edge DONE rises.
  assign bus.BTN_OUT   = btn_q;
  assign bus.BUSY      = (state_q == ST_BOUNCE) || (state_q == ST_SETTLE);
  assign bus.DONE      = done_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_q;
  assign bus.dbg_lfsr  = lfsr_q;

endmodule

// File: tb/tb_cv_btn_bounce_gen.sv
module tb_cv_btn_bounce_gen;
  import cv_bounce_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv_btn_bounce_gen_if #(.CNT_WIDTH(5)) bus ();

  cv_btn_bounce_gen #(
    .CNT_WIDTH  (5),
    .BOUNCE_LEN (12),
    .SETTLE_LEN (20),
    .SEED       (8'hA5)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Reference debounce filter, CNTR_WIDTH=4: the output flips after 16
  // consecutive CE samples that differ from it.
  logic       flt_q;
  logic [3:0] fcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q  <= 1'b0;
      fcnt_q <= '0;
    end else if (bus.CE) begin
      if (bus.BTN_OUT != flt_q) begin
        if (fcnt_q == 4'd15) begin
          flt_q  <= bus.BTN_OUT;
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 4'd1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc(input logic ce);
    bus.CE = ce;
    @(posedge clk);
    #1;
    bus.CE = 1'b0;
  endtask

  // CE is high on every 4th CLK.
  task automatic ce_tick();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
  endtask

  // Runs CE ticks until DONE is seen (bounded), then checks the tick count.
  task automatic wait_done(input string name, input int max_ticks, input int exp_ticks);
    int got;
    got = -1;
    for (int t = 1; t <= max_ticks; t++) begin
      ce_tick();
      if (bus.DONE) begin
        got = t;
        break;
      end
    end
    check(name, got, exp_ticks);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic       exp_btn;
    logic [7:0] exp_lfsr;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[12];
  int   bad;

  initial begin
    // LFSR steps 1..12 from 8'hA5; BTN_OUT shows bit0 on ticks 1..11, TGT=1 on tick 12.
    vecs[0]  = '{1'b0, 8'hEA, ST_BOUNCE};
    vecs[1]  = '{1'b1, 8'h75, ST_BOUNCE};
    vecs[2]  = '{1'b0, 8'h82, ST_BOUNCE};
    vecs[3]  = '{1'b1, 8'h41, ST_BOUNCE};
    vecs[4]  = '{1'b0, 8'h98, ST_BOUNCE};
    vecs[5]  = '{1'b0, 8'h4C, ST_BOUNCE};
    vecs[6]  = '{1'b0, 8'h26, ST_BOUNCE};
    vecs[7]  = '{1'b1, 8'h13, ST_BOUNCE};
    vecs[8]  = '{1'b1, 8'hB1, ST_BOUNCE};
    vecs[9]  = '{1'b0, 8'hE0, ST_BOUNCE};
    vecs[10] = '{1'b0, 8'h70, ST_BOUNCE};
    vecs[11] = '{1'b1, 8'h38, ST_SETTLE};

    bus.CE     = 1'b0;
    bus.LVL_IN = 1'b0;

    // ---- reset ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_btn",   bus.BTN_OUT,   0);
    check("rst_busy",  bus.BUSY,      0);
    check("rst_done",  bus.DONE,      0);
    check("rst_state", bus.dbg_state, ST_IDLE);
    check("rst_lfsr",  bus.dbg_lfsr,  8'hA5);
    check("rst_cnt",   bus.dbg_cnt,   0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      ce_tick();
      if (bus.BUSY || bus.BTN_OUT || bus.DONE) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_lfsr",  bus.dbg_lfsr, 8'hA5);

    // ---- rise, table-driven ----
    bus.LVL_IN = 1'b1;
    cyc(1'b0);
    check("rise_busy", bus.BUSY, 1);
    for (int i = 0; i < 12; i++) begin
      ce_tick();
      check($sformatf("rise_btn[%0d]", i),   bus.BTN_OUT,   vecs[i].exp_btn);
      check($sformatf("rise_lfsr[%0d]", i),  bus.dbg_lfsr,  vecs[i].exp_lfsr);
      check($sformatf("rise_state[%0d]", i), bus.dbg_state, vecs[i].exp_state);
    end
    wait_done("rise_settle_ticks", 40, 20);
    check("rise_done_busy", bus.BUSY,    0);
    check("rise_btn_final", bus.BTN_OUT, 1);
    cyc(1'b0);
    check("rise_done_pulse", bus.DONE, 0);
    check("rise_stay_idle",  bus.BUSY, 0);

    // ---- CE stall during BOUNCE ----
    bus.LVL_IN = 1'b0;
    cyc(1'b0);
    check("stall_busy", bus.BUSY, 1);
    repeat (6) ce_tick();
    check("stall_lfsr6", bus.dbg_lfsr, 8'hCA);
    check("stall_cnt6",  bus.dbg_cnt,  6);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0);
      if (bus.dbg_lfsr !== 8'hCA || bus.dbg_cnt !== 5'd6 || bus.BTN_OUT !== 1'b0
          || bus.dbg_state !== ST_BOUNCE) bad++;
    end
    check("stall_frozen", bad, 0);
    repeat (5) ce_tick();
    check("stall_still_bounce", bus.dbg_state, ST_BOUNCE);
    ce_tick();
    check("stall_to_settle", bus.dbg_state, ST_SETTLE);
    check("stall_btn",       bus.BTN_OUT,   0);
    check("stall_cnt0",      bus.dbg_cnt,   0);
    wait_done("stall_settle_ticks", 40, 20);

    // ---- LVL_IN change mid-burst ----
    bus.LVL_IN = 1'b1;
    cyc(1'b0);
    repeat (5) ce_tick();
    bus.LVL_IN = 1'b0;
    wait_done("mid_first_ticks", 60, 27);
    check("mid_first_btn",  bus.BTN_OUT, 1);
    check("mid_first_busy", bus.BUSY,    0);
    cyc(1'b0);
    check("mid_rebusy", bus.BUSY, 1);
    check("mid_nodone", bus.DONE, 0);
    wait_done("mid_second_ticks", 60, 32);
    check("mid_second_btn", bus.BTN_OUT, 0);

    // ---- async reset during the 7th BOUNCE tick ----
    bus.LVL_IN = 1'b1;
    cyc(1'b0);
    repeat (6) ce_tick();
    cyc(1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_btn",   bus.BTN_OUT,   0);
    check("arst_busy",  bus.BUSY,      0);
    check("arst_done",  bus.DONE,      0);
    check("arst_state", bus.dbg_state, ST_IDLE);
    check("arst_lfsr",  bus.dbg_lfsr,  8'hA5);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cyc(1'b0);
    check("arst_rebusy", bus.BUSY, 1);
    repeat (11) ce_tick();
    check("arst_bounce11", bus.dbg_state, ST_BOUNCE);
    check("arst_lfsr11",   bus.dbg_lfsr,  8'h70);
    ce_tick();
    check("arst_settle12", bus.dbg_state, ST_SETTLE);
    check("arst_btn12",    bus.BTN_OUT,   1);
    wait_done("arst_settle_ticks", 40, 20);
    check("loop_after_arst", flt_q, 1);

    // ---- loopback into the filter: release then press ----
    bus.LVL_IN = 1'b0;
    cyc(1'b0);
    wait_done("loop_rel_ticks", 60, 32);
    check("loop_release", flt_q, 0);
    bus.LVL_IN = 1'b1;
    cyc(1'b0);
    wait_done("loop_press_ticks", 60, 32);
    check("loop_press", flt_q, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv_btn_bounce_gen.md
Name: cv_btn_bounce_gen

Overview:
- Synthesizable contact-bounce emulator. It is the transmitter-side counterpart of the button debounce filter.
- Takes a clean command level (from on-chip test logic or a switch register) and drives a "mechanical" output that chatters pseudo-randomly for a fixed number of CE ticks, then holds the new level.
- Used for on-board self-test of the debounce/sequence path: loops back into the filter input instead of a real button.

Parameters:
- CNT_WIDTH, 5, width of the tick counter; BOUNCE_LEN and SETTLE_LEN must be < 2^CNT_WIDTH.
- BOUNCE_LEN, 12, CE ticks of chatter per transition; must be ≥ 1.
- SETTLE_LEN, 20, CE ticks BTN_OUT is held stable before DONE; must be ≥ 1; ≥ 2^filter CNTR_WIDTH + 4 for loopback use.
- SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- CE  in  1  tick enable (same CE as the downstream filter)
- LVL_IN  in  1  clean command level, synchronous to CLK
- BTN_OUT  out  1  bouncing emulated contact output, registered
- BUSY  out  1  high while in BOUNCE or SETTLE
- DONE  out  1  one-CLK pulse when a transition has fully settled

Behaviour:
- Interface: reset RST, asynchronous, active-high; clock CLK.
- Reset values:
  - BTN_OUT=0, BUSY=0, DONE=0.
  - State=IDLE, target level TGT=0, tick counter=0, LFSR=SEED.
- IDLE:
  - Every CLK edge, independent of CE, compare LVL_IN with TGT.
  - On mismatch: TGT<=LVL_IN, counter<=0, state<=BOUNCE, so BUSY=1 one CLK after LVL_IN changes.
  - BTN_OUT holds TGT.
- BOUNCE, on each CE:
  - LFSR advances one step.
  - Counter increments.
  - BTN_OUT<=lfsr_next[0].
  - On the CE where counter==BOUNCE_LEN-1: BTN_OUT<=TGT (overrides the LFSR bit), counter<=0, state<=SETTLE.
  - Result: exactly BOUNCE_LEN CE ticks spent in BOUNCE, and the last one drives TGT.
- SETTLE:
  - BTN_OUT held at TGT; counter increments on CE.
  - On the CE where counter==SETTLE_LEN-1: state<=IDLE, DONE<=1 for one CLK, BUSY<=0 on the same edge.
  - DONE and BUSY are never high together.
- CE low: counter, LFSR and BTN_OUT are frozen in BOUNCE and SETTLE. IDLE mismatch detection still runs.
- LVL_IN changes during BOUNCE/SETTLE are ignored and not queued.
  - TGT is re-compared in IDLE.
  - If LVL_IN≠TGT on return to IDLE, a new burst starts on the next CLK edge (BUSY re-asserts one CLK after DONE).
  - A pulse on LVL_IN that returns to TGT before IDLE is lost.
- LFSR: 8-bit Galois, taps 8'hB8 (x^8+x^6+x^5+x^4+1), period 255. It never reaches zero given a non-zero SEED, and advances only in BOUNCE on CE.
- Reset mid-operation returns everything to reset values immediately (async). If LVL_IN=1 at release, a burst starts one CLK after the first edge.
- All arithmetic is unsigned. The counter never wraps because the terminal compare always precedes overflow.

Decomposition:
- Package cv_bounce_pkg:
  - State encoding: IDLE=2'b00, BOUNCE=2'b01, SETTLE=2'b10; 2'b11 recovers to IDLE.
  - LFSR_TAPS=8'hB8.
  - LFSR width constant 8.
- Sub-module cv_lfsr8: Galois LFSR with inputs CLK, RST, EN and parameter SEED; outputs Q[7:0] and Q_NEXT[7:0].
- The FSM, counter and output register stay in the top module.

Test Plan:
- Reset: assert RST for 3 CLK with LVL_IN=0 → BTN_OUT=0, BUSY=0, DONE=0; no activity for 100 CLK.
- Rise (CE every 4th CLK, defaults):
  - LVL_IN 0→1 → BUSY=1 after 1 CLK.
  - BTN_OUT follows bit0 of LFSR steps 1..11 from SEED 8'hA5 on each CE, and equals 1 on the 12th CE.
  - After 20 further CE: DONE pulses once, BUSY=0.
- Mid-burst change:
  - LVL_IN 0→1, then back to 0 after 5 CE → burst completes to 1 and DONE fires.
  - BUSY re-asserts the next CLK and a new burst settles BTN_OUT=0.
- CE stall: hold CE=0 for 50 CLK in BOUNCE after the 6th tick → BTN_OUT, counter and LFSR unchanged; resume → 6 more CE to SETTLE.
- Async reset at the 7th BOUNCE tick with LVL_IN=1 → outputs 0 immediately, LFSR=8'hA5; after release a fresh burst of exactly 12 CE ticks.
- Loopback into the debounce filter (CNTR_WIDTH=4, shared CE), press then release → after each DONE the filter's clean output equals LVL_IN.
